// File: rtl/fifo_rd_stream_pkg.sv
// fifo_rd_stream_pkg
//   Shared definitions for the synchronous FIFO read-side logic.
//   - occ_t             : output buffer occupancy (EMPTY/ONE/TWO)
//   - FIFO_RD_LATENCY   : cycles from fifo_sync read strobe to valid read data
//   - FIFO_DEFAULT_DATA_WIDTH : default word width used by fifo_sync
package fifo_rd_stream_pkg;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_t;

  localparam int unsigned FIFO_RD_LATENCY         = 1;
  localparam int unsigned FIFO_DEFAULT_DATA_WIDTH = 32;

endpackage

// File: rtl/fifo_rd_stream_stats.sv
// fifo_rd_stream_stats
//   Transfer and stall counters for fifo_rd_stream. The module exists only
//   when FIFO_RD_STREAM_STATS_EN is defined; otherwise no counter logic is built.
//   Ports:
//     i_clk, i_rst       : clock, synchronous active-high reset (clears counters)
//     i_pop              : a stream word was accepted this cycle
//     i_stall            : a stream word was offered but not accepted
//     o_xfer_count [31:0]: accepted words, wraps at 2^32
//     o_stall_count[31:0]: stall cycles, wraps at 2^32
`ifdef FIFO_RD_STREAM_STATS_EN
module fifo_rd_stream_stats
  import fifo_rd_stream_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_pop,
  input  logic        i_stall,
  output logic [31:0] o_xfer_count,
  output logic [31:0] o_stall_count
);

  logic [31:0] r_xfer;
  logic [31:0] r_stall;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_xfer  <= '0;
      r_stall <= '0;
    end else begin
      if (i_pop)   r_xfer  <= r_xfer + 32'd1;
      if (i_stall) r_stall <= r_stall + 32'd1;
    end
  end

  assign o_xfer_count  = r_xfer;
  assign o_stall_count = r_stall;

endmodule
`endif

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream
//   Read-side adapter for fifo_sync: turns the empty/read-strobe interface
//   (data valid one cycle after the strobe) into a full-throughput valid/ready
//   stream using a 2-entry output buffer and in-flight read tracking.
//   Optional counters: define FIFO_RD_STREAM_STATS_EN to add o_xfer_count and
//   o_stall_count (sub-module fifo_rd_stream_stats).
//   Ports:
//     i_clk, i_rst   : clock, synchronous active-high reset
//     i_fifo_empty   : fifo_sync o_empty
//     o_fifo_rd      : read strobe to fifo_sync i_rd
//     i_fifo_data    : fifo_sync read data (valid the cycle after o_fifo_rd)
//     o_valid/o_data : stream word (registered), held while stalled
//     i_ready        : downstream accept
//     o_xfer_count, o_stall_count : stats (FIFO_RD_STREAM_STATS_EN only)
module fifo_rd_stream
  import fifo_rd_stream_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = FIFO_DEFAULT_DATA_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_fifo_empty,
  output logic                  o_fifo_rd,
  input  logic [DATA_WIDTH-1:0] i_fifo_data,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  input  logic                  i_ready
`ifdef FIFO_RD_STREAM_STATS_EN
  ,
  output logic [31:0]           o_xfer_count,
  output logic [31:0]           o_stall_count
`endif
);

  occ_t                  r_occ;
  logic                  r_inflight;
  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_buf0;
  logic [DATA_WIDTH-1:0] r_buf1;

  logic                  w_pop;
  logic [2:0]            w_level;
  logic                  w_fifo_rd;

  assign w_pop = r_valid & i_ready;

  // Committed words after this cycle's pop; pop implies occ >= 1, so no underflow.
  assign w_level   = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_fifo_rd = ~i_rst & ~i_fifo_empty & (w_level < 3'd2);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_occ      <= OCC_EMPTY;
      r_inflight <= 1'b0;
      r_valid    <= 1'b0;
      r_buf0     <= '0;
      r_buf1     <= '0;
    end else begin
      r_inflight <= w_fifo_rd;
      // Returning data lands in the slot after the head, as seen after the pop.
      case (r_occ)
        OCC_EMPTY: begin
          if (r_inflight) begin
            r_buf0  <= i_fifo_data;
            r_occ   <= OCC_ONE;
            r_valid <= 1'b1;
          end
        end
        OCC_ONE: begin
          if (r_inflight) begin
            if (w_pop) begin
              r_buf0 <= i_fifo_data;
            end else begin
              r_buf1 <= i_fifo_data;
              r_occ  <= OCC_TWO;
            end
          end else if (w_pop) begin
            r_occ   <= OCC_EMPTY;
            r_valid <= 1'b0;
          end
        end
        OCC_TWO: begin
          // No read can be in flight here: reads stop once two words are committed.
          if (w_pop) begin
            r_buf0 <= r_buf1;
            r_occ  <= OCC_ONE;
          end
        end
        default: begin
          r_occ   <= OCC_EMPTY;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_fifo_rd = w_fifo_rd;
  assign o_valid   = r_valid;
  assign o_data    = r_buf0;

`ifdef FIFO_RD_STREAM_STATS_EN
  fifo_rd_stream_stats u_stats (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_pop         (w_pop),
    .i_stall       (r_valid & ~i_ready),
    .o_xfer_count  (o_xfer_count),
    .o_stall_count (o_stall_count)
  );
`endif

`ifdef FORMAL
  a_no_two_push: assert property (@(posedge i_clk) disable iff (i_rst)
    !(r_occ == OCC_TWO && r_inflight));
  a_stall_stable: assert property (@(posedge i_clk) disable iff (i_rst)
    (o_valid && !i_ready) |=> $stable(o_data));
  a_occ_bound: assert property (@(posedge i_clk) disable iff (i_rst)
    (({1'b0, r_occ} + {2'b00, r_inflight}) <= 3'd2));
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream
//   Drives fifo_rd_stream from a queue-based model of fifo_sync (one-cycle read
//   latency) and checks the stream against the order in which words were
//   loaded into that FIFO. Counter checks are included when
//   FIFO_RD_STREAM_STATS_EN is defined.
module tb_fifo_rd_stream;

  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_fifo_empty = 1'b1;
  logic          o_fifo_rd;
  logic [DW-1:0] i_fifo_data = '0;
  logic          o_valid;
  logic [DW-1:0] o_data;
  logic          i_ready = 1'b0;
`ifdef FIFO_RD_STREAM_STATS_EN
  logic [31:0]   o_xfer_count;
  logic [31:0]   o_stall_count;
`endif

  fifo_rd_stream #(.DATA_WIDTH(DW)) dut (
    .i_clk        (clk),
    .i_rst        (i_rst),
    .i_fifo_empty (i_fifo_empty),
    .o_fifo_rd    (o_fifo_rd),
    .i_fifo_data  (i_fifo_data),
    .o_valid      (o_valid),
    .o_data       (o_data),
    .i_ready      (i_ready)
`ifdef FIFO_RD_STREAM_STATS_EN
    ,
    .o_xfer_count (o_xfer_count),
    .o_stall_count(o_stall_count)
`endif
  );

  always #5 clk = ~clk;

  int unsigned   checks = 0;
  int unsigned   failures = 0;
  logic [31:0]   fifo_q[$];     // contents of the modelled fifo_sync
  logic [31:0]   exp_q[$];      // expected stream order
  bit            rd_pending = 0;
  logic [31:0]   rd_word = '0;
  int            outstanding = 0; // words read from the FIFO but not yet accepted
  int            ready_mode = 0;  // 0: low, 1: high, 2: random, 3: 1,0,0,1 pattern
  int            pat_idx = 0;
  bit            hold_nonempty = 0;
  int unsigned   n_pop = 0;
  int unsigned   n_stall = 0;
  bit            prev_stall = 0;
  logic [31:0]   prev_data = '0;
  logic [3:0]    pat = 4'b1001;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic load(input int n, input logic [31:0] base, input bit rnd);
    for (int i = 0; i < n; i++) begin
      logic [31:0] w;
      w = rnd ? 32'($urandom) : base + 32'(i);
      fifo_q.push_back(w);
      exp_q.push_back(w);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, then model the FIFO read.
  task automatic step(input bit rst);
    @(negedge clk);
    i_rst = rst;
    if (rst) begin
      fifo_q.delete();
      exp_q.delete();
      rd_pending  = 0;
      outstanding = 0;
      n_pop       = 0;
      n_stall     = 0;
    end
    i_fifo_data  = rd_pending ? rd_word : 32'($urandom);
    rd_pending   = 0;
    i_fifo_empty = hold_nonempty ? 1'b0 : (fifo_q.size() == 0);
    case (ready_mode)
      0: i_ready = 1'b0;
      1: i_ready = 1'b1;
      2: i_ready = 1'($urandom_range(0, 1));
      default: begin
        i_ready = pat[pat_idx % 4];
        pat_idx++;
      end
    endcase
    #1;
    if (o_fifo_rd) begin
      checks++;
      if (fifo_q.size() == 0) begin
        failures++;
        $display("FAIL read_when_empty: got o_fifo_rd=1 expected 0");
      end else begin
        rd_word    = fifo_q.pop_front();
        rd_pending = 1;
        outstanding++;
      end
    end
  endtask

  task automatic drain(input string name, input int bound);
    int n;
    n = 0;
    ready_mode = 1;
    while (exp_q.size() != 0 && n < bound) begin
      step(0);
      #2;
      n++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: compares accepted words with the expected order, checks hold under stall.
  always @(negedge clk) begin
    #2;
    if (i_rst) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        check("stall_valid_hold", {31'd0, o_valid}, 32'd1);
        check("stall_data_hold", o_data, prev_data);
      end
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word: got 0x%08h expected none", o_data);
        end else begin
          check("stream_word", o_data, exp_q.pop_front());
        end
        outstanding--;
        n_pop++;
      end
      if (o_valid && !i_ready) n_stall++;
      checks++;
      if (outstanding > 2 || outstanding < 0) begin
        failures++;
        $display("FAIL occupancy: got %0d expected 0..2", outstanding);
      end
      prev_stall = o_valid && !i_ready;
      prev_data  = o_data;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit seen;
    int vcount;

    // Reset with a non-empty FIFO: nothing may be read or presented.
    hold_nonempty = 1;
    ready_mode    = 1;
    repeat (3) begin
      step(1);
      check("rst_fifo_rd", {31'd0, o_fifo_rd}, 32'd0);
      check("rst_valid", {31'd0, o_valid}, 32'd0);
      check("rst_data", o_data, 32'd0);
    end
    hold_nonempty = 0;

    // Single word: read in N, valid only in N+2.
    load(1, 32'hDEADBEEF, 0);
    step(0);
    check("single_rd_N", {31'd0, o_fifo_rd}, 32'd1);
    check("single_valid_N", {31'd0, o_valid}, 32'd0);
    step(0);
    check("single_rd_N1", {31'd0, o_fifo_rd}, 32'd0);
    check("single_valid_N1", {31'd0, o_valid}, 32'd0);
    step(0);
    check("single_valid_N2", {31'd0, o_valid}, 32'd1);
    check("single_data_N2", o_data, 32'hDEADBEEF);
    step(0);
    check("single_valid_N3", {31'd0, o_valid}, 32'd0);
    check("single_rd_N3", {31'd0, o_fifo_rd}, 32'd0);
    check("single_fifo_empty", 32'(fifo_q.size()), 32'd0);

    // Streaming: 16 words with no bubbles after the first.
    load(16, 32'd0, 0);
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step(0);
      if (o_valid) seen = 1;
    end
    check("stream_first_valid", {31'd0, seen}, 32'd1);
    vcount = seen ? 1 : 0;
    repeat (15) begin
      step(0);
      if (o_valid) vcount++;
    end
    check("stream_consecutive", 32'(vcount), 32'd16);
    drain("stream_drain", 20);

    // Backpressure with ready pattern 1,0,0,1.
    load(8, 32'd100, 0);
    ready_mode = 3;
    pat_idx    = 0;
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
      step(0);
      #2;
    end
    check("bp_drain", 32'(exp_q.size()), 32'd0);

    // FIFO empties mid-stream: valid low through the gap.
    load(2, 32'd200, 0);
    drain("gap_first_drain", 20);
    repeat (5) begin
      step(0);
      check("gap_valid", {31'd0, o_valid}, 32'd0);
    end
    load(2, 32'd300, 0);
    drain("gap_second_drain", 20);

    // Random loads and random backpressure.
    ready_mode = 2;
    repeat (400) begin
      if ($urandom_range(0, 2) == 0) load(1, 32'd0, 1);
      step(0);
    end
    drain("random_drain", 300);

    // Reset while the buffer holds two words.
    load(6, 32'd400, 0);
    ready_mode = 0;
    repeat (6) step(0);
    check("pre_reset_valid", {31'd0, o_valid}, 32'd1);
`ifdef FIFO_RD_STREAM_STATS_EN
    check("pre_reset_xfer", o_xfer_count, n_pop);
    check("pre_reset_stall", o_stall_count, n_stall);
`endif
    step(1);
    step(0);
    check("post_reset_valid", {31'd0, o_valid}, 32'd0);
    check("post_reset_data", o_data, 32'd0);
`ifdef FIFO_RD_STREAM_STATS_EN
    check("post_reset_xfer", o_xfer_count, 32'd0);
    check("post_reset_stall", o_stall_count, 32'd0);
`endif

    // Normal operation resumes after reset.
    load(3, 32'd500, 0);
    drain("post_reset_drain", 20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_rd_stream.md
# fifo_rd_stream

Read-side adapter sitting directly downstream of `fifo_sync`. Converts the FIFO's read-strobe interface (`o_empty`, one-cycle registered read data) into a valid/ready stream with full throughput and no combinational path from downstream `i_ready` into the FIFO's data output. It uses a 2-entry output buffer plus in-flight read tracking, so backpressure never drops or duplicates a word.

## Interface
- `DATA_WIDTH`, 32: word width; must match `fifo_sync` data width.
- `i_clk`  in  1  system clock, shared with `fifo_sync`.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_fifo_empty`  in  1  `o_empty` of upstream `fifo_sync`.
- `o_fifo_rd`  out  1  read strobe to `fifo_sync` `i_rd`.
- `i_fifo_data`  in  DATA_WIDTH  `fifo_sync` read data, valid the cycle after `o_fifo_rd`.
- `o_valid`  out  1  stream word available.
- `o_data`  out  DATA_WIDTH  stream word; stable while `o_valid && !i_ready`.
- `i_ready`  in  1  downstream accepts word this cycle.
- `o_xfer_count`  out  32  accepted words (only with `FIFO_RD_STREAM_STATS_EN`).
- `o_stall_count`  out  32  cycles with `o_valid && !i_ready` (only with `FIFO_RD_STREAM_STATS_EN`).

## Operation
- State:
  - buffer occupancy `occ` ∈ {EMPTY=0, ONE=1, TWO=2};
  - `inflight` flag, meaning a read was issued last cycle;
  - two entries `buf0` (head) and `buf1`.
- `pop = o_valid && i_ready`.
- `o_fifo_rd = !i_rst && !i_fifo_empty && (occ + inflight - pop) < 2`. This is combinational from registered state, `i_fifo_empty` and `i_ready`.
- `inflight <= o_fifo_rd` each cycle.
- When `inflight` is set, `i_fifo_data` is written into the slot after the head. The write target is computed after applying this cycle's pop.
- Occupancy transitions, with push = `inflight`:
  - EMPTY + push → ONE.
  - ONE + push + pop → ONE.
  - ONE + push → TWO.
  - ONE + pop → EMPTY.
  - TWO + pop → ONE, `buf1` shifts to `buf0`.
  - TWO + push is impossible by construction; assert it under formal.
- `o_valid = (occ != EMPTY)`; `o_data = buf0`. Both are registered.
- Ordering is strict FIFO. Every word read from `fifo_sync` appears exactly once on the stream.
- Arithmetic: the `occ + inflight - pop` expression is evaluated in 3-bit unsigned. It never underflows, because pop implies occ ≥ 1.

## Timing
- Reset values:
  - `o_valid`=0, `o_data`=0, `o_fifo_rd`=0;
  - `occ`=EMPTY, `inflight`=0;
  - counters = 0.
- Latency: `i_fifo_empty` falls in cycle N → `o_fifo_rd`=1 in N → data captured end of N+1 → `o_valid`=1 in N+2.
- Throughput: one word per cycle while `i_ready`=1 and the FIFO is non-empty. Steady state is `occ`=ONE, `inflight`=1.
- Backpressure:
  - `i_ready` low with ONE + inflight → TWO, and `o_fifo_rd` drops the same cycle.
  - `i_ready` returning high in TWO pops and issues a read in the same cycle (2+0-1 < 2).
- FIFO goes empty mid-stream: `o_fifo_rd`=0 immediately; buffered words still drain.
- Reset mid-operation: buffer and `inflight` are cleared. Data returning the cycle after reset is discarded. `fifo_sync` must be reset in the same cycle; otherwise an in-flight word is lost.
- `i_ready` may be asserted while `o_valid`=0; it has no effect.

## Configuration
- `FIFO_RD_STREAM_STATS_EN` defined:
  - `o_xfer_count` increments on each pop; `o_stall_count` increments on each `o_valid && !i_ready` cycle.
  - Both are 32-bit, wrap at 2^32, and clear on `i_rst`.
- Undefined: both ports are absent and no counter logic is generated.

## Structure
- The shared fifo package holds:
  - the occupancy state typedef (EMPTY/ONE/TWO);
  - the `FIFO_RD_LATENCY`=1 constant;
  - the default data width constant used by `fifo_sync`.
- One sub-module, `fifo_rd_stream_stats`, holds the two counters. It is instantiated only under the macro.
- Formal properties, under the existing formal guard:
  - no TWO+push;
  - `o_data` stable under stall;
  - `occ + inflight` ≤ 2.

## Test plan
- **Reset and idle:** hold `i_rst`=1 for 3 cycles with `i_fifo_empty`=0 → `o_fifo_rd`=0, `o_valid`=0, `o_data`=0 throughout.
- **Single word:** FIFO holds 0xDEADBEEF, `i_ready`=1 → `o_fifo_rd` pulses once in cycle N; `o_valid`=1 with 0xDEADBEEF only in N+2; the FIFO is empty afterwards.
- **Streaming:** FIFO holds 0..15, `i_ready`=1 → 16 consecutive `o_valid` cycles carrying 0..15 in order; zero bubbles after the first word.
- **Backpressure:** stream 0..7 with `i_ready` toggling 1,0,0,1 repeating → all 8 words in order, no duplicates. `o_data` is held during each stall, and `occ` never exceeds 2.
- **Empty mid-stream:** FIFO holds 2 words, then 5 idle cycles, then 2 more words → output 4 words in order; `o_valid` is low during the gap.
- **Reset mid-stream, with the macro defined:** assert `i_rst` while `occ`=TWO → next cycle `o_valid`=0 and both counters = 0. Before the reset, `o_xfer_count` equals the number of pops and `o_stall_count` equals the number of stall cycles.
